// File: rtl/maxpool_2x2_if.sv
// Pixel-stream bundle for the 2x2 max-pooling block: raster pixels in, pooled results out.
// The master modport belongs to the pixel source, the slave modport to the pooling block.
interface maxpool_2x2_if #(
    parameter int IMG_W  = 64,
    parameter int DATA_W = 19
);
    localparam int ADDR_W = 2 * $clog2(IMG_W) - 2;

    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_sel;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic [ADDR_W-1:0] o_addr;
    logic              o_sel;

    modport master (
        output i_valid, i_data, i_sel,
        input  o_valid, o_data, o_addr, o_sel
    );

    modport slave (
        input  i_valid, i_data, i_sel,
        output o_valid, o_data, o_addr, o_sel
    );
endinterface

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 max pooling over an IMG_W x IMG_W raster frame, one pooled result per 2x2 tile.
// Optional feature macro MAXPOOL_FRAME_DONE_EN adds o_frame_done, high with the last result of a frame.
module maxpool_2x2 #(
    parameter int IMG_W  = 64,
    parameter int DATA_W = 19
) (
    input  logic         clk,
    input  logic         reset,
    maxpool_2x2_if.slave bus
`ifdef MAXPOOL_FRAME_DONE_EN
    ,
    output logic         o_frame_done
`endif
);
    localparam int              LW      = $clog2(IMG_W);
    localparam int              HALF_W  = IMG_W / 2;
    localparam logic [LW-1:0]   MAX_POS = LW'(IMG_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [LW-1:0]     col;
    logic [LW-1:0]     row;
    logic [DATA_W-1:0] hreg;
    logic              frame_id;
    logic [DATA_W-1:0] line_buf [HALF_W];

    logic              last_col;
    logic              last_row;
    logic              odd_row;
    logic              buf_wr;
    logic              fire;
    logic [DATA_W-1:0] pair;
    logic [DATA_W-1:0] above;
    logic [DATA_W-1:0] pooled;

    assign last_col = (col == MAX_POS);
    assign last_row = (row == MAX_POS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE always coincides with pixel (0,0), so it is treated as an even row.
    always_comb begin
        state_d = state_q;
        odd_row = (state_q == ODD_ROW);
        buf_wr  = bus.i_valid && !odd_row && col[0];
        fire    = bus.i_valid && odd_row && col[0];
        pair    = (hreg > bus.i_data) ? hreg : bus.i_data;
        above   = line_buf[col[LW-1:1]];
        pooled  = (above > pair) ? above : pair;
        if (bus.i_valid) begin
            case (state_q)
                IDLE:     state_d = EVEN_ROW;
                EVEN_ROW: if (last_col) state_d = ODD_ROW;
                ODD_ROW:  if (last_col) state_d = last_row ? IDLE : EVEN_ROW;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            hreg     <= '0;
            frame_id <= 1'b0;
        end else if (bus.i_valid) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) begin
                row <= last_row ? '0 : row + 1'b1;
            end
            if (!col[0]) begin
                hreg <= bus.i_data;
            end
            if (row == '0 && col == '0) begin
                frame_id <= bus.i_sel;
            end
        end
    end

    // The line buffer is always written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            line_buf[col[LW-1:1]] <= pair;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_addr  <= '0;
            bus.o_sel   <= 1'b0;
        end else begin
            bus.o_valid <= fire;
            if (fire) begin
                bus.o_data <= pooled;
                bus.o_addr <= {row[LW-1:1], col[LW-1:1]};
                bus.o_sel  <= frame_id;
            end
        end
    end

`ifdef MAXPOOL_FRAME_DONE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= fire && last_row && last_col;
        end
    end
`endif
endmodule
